// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_OFF       : all segments dark (active-low encoding)
//   SEG_0..SEG_F  : hex glyphs, bit order {g,f,e,d,c,b,a}, active-low
//   f_an_onehot   : one-hot anode pattern for a digit index, optionally inverted
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    // Widest anode vector the helper can build; callers truncate to their digit count.
    localparam int MAX_DIGITS = 32;

    function automatic logic [MAX_DIGITS-1:0] f_an_onehot(input logic [4:0] idx,
                                                          input logic       active_low);
        logic [MAX_DIGITS-1:0] oh;
        oh = {{(MAX_DIGITS-1){1'b0}}, 1'b1} << idx;
        return active_low ? ~oh : oh;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to seven-segment decode.
//   nib_i : 4-bit value to display
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            default: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller.
//   clk, reset  : system clock, asynchronous active-high reset
//   upd_valid   : producer offers a new display image
//   upd_ready   : image can be accepted (no update pending)
//   upd_digits  : nibble per digit, [3:0] is digit 0 (rightmost)
//   upd_dp      : decimal point per digit, active-high
//   upd_blank   : force digit dark, active-high
//   an          : anode enables, polarity set by AN_ACTIVE_LOW
//   seg, dp     : segments {g,f,e,d,c,b,a} and decimal point, active-low
//   frame_done  : one-cycle pulse after the last digit slot ends
// Handshake: a transfer happens on a clock edge where upd_valid && upd_ready.
// The image lands in a shadow copy and is committed to the displayed image
// only at a frame boundary, so a frame is never drawn from two images.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_CYCLES  = 1000,
    parameter int AN_ACTIVE_LOW = 1,
    parameter int LZ_SUPPRESS   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_digits,
    input  logic [NUM_DIGITS-1:0]   upd_dp,
    input  logic [NUM_DIGITS-1:0]   upd_blank,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic             AN_LOW    = (AN_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_LOW}};

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] shd_dig_q, shd_dig_d, act_dig_q, act_dig_d;
    logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   shd_blk_q, shd_blk_d, act_blk_q, act_blk_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    fd_q, fd_d;

    logic                    slot_end, frame_end;
    logic [3:0]              act_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_run;
    logic                    lz_blank;
    logic [6:0]              dec_seg;

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign upd_ready = ~pend_q;

    // Prescaler and digit index, both wrapped by explicit compare.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Commit and capture are exclusive: a capture needs pend_q=0, a commit needs pend_q=1.
    // A capture in the frame_end cycle therefore waits for the following frame.
    always_comb begin
        pend_d    = pend_q;
        shd_dig_d = shd_dig_q;
        shd_dp_d  = shd_dp_q;
        shd_blk_d = shd_blk_q;
        act_dig_d = act_dig_q;
        act_dp_d  = act_dp_q;
        act_blk_d = act_blk_q;
        if (frame_end && pend_q) begin
            act_dig_d = shd_dig_q;
            act_dp_d  = shd_dp_q;
            act_blk_d = shd_blk_q;
            pend_d    = 1'b0;
        end else if (upd_valid && upd_ready) begin
            shd_dig_d = upd_digits;
            shd_dp_d  = upd_dp;
            shd_blk_d = upd_blank;
            pend_d    = 1'b1;
        end
    end

    // lz_run[i]: every nibble from the top digit down to i is zero.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            act_nib[i] = act_dig_q[4*i +: 4];
        end
        lz_run = '0;
        lz_run[NUM_DIGITS-1] = (act_nib[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz_run[i] = lz_run[i+1] && (act_nib[i] == 4'h0);
        end
        lz_blank = (LZ_SUPPRESS != 0) && (idx_q != '0) && lz_run[idx_q];
    end

    hex7seg u_dec (
        .nib_i (act_nib[idx_q]),
        .seg_o (dec_seg)
    );

    // Output image for the current slot; forced blanking also hides dp,
    // leading-zero blanking keeps the digit's dp.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        fd_d  = frame_end;
        if (cnt_q >= CNT_BLANK) begin
            an_d = NUM_DIGITS'(f_an_onehot(5'(idx_q), AN_LOW));
            if (!act_blk_q[idx_q]) begin
                dp_d = ~act_dp_q[idx_q];
                if (!lz_blank) begin
                    seg_d = dec_seg;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= 1'b0;
            shd_dig_q <= '0;
            shd_dp_q  <= '0;
            shd_blk_q <= '0;
            act_dig_q <= '0;
            act_dp_q  <= '0;
            act_blk_q <= '0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            shd_dig_q <= shd_dig_d;
            shd_dp_q  <= shd_dp_d;
            shd_blk_q <= shd_blk_d;
            act_dig_q <= act_dig_d;
            act_dp_q  <= act_dp_d;
            act_blk_q <= act_blk_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a 4-digit instance (DIV 8, blank 2, active-low
// anodes) driven through the update port, and a 3-digit instance (DIV 5,
// active-high anodes) left idle, both compared every cycle against a model
// computed from the cycle number since reset and the committed image.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        upd_valid;
  logic [15:0] upd_digits;
  logic [3:0]  upd_dp;
  logic [3:0]  upd_blank;

  logic        rdy_a, fd_a, dp_a;
  logic [3:0]  an_a;
  logic [6:0]  seg_a;
  logic        rdy_b, fd_b, dp_b;
  logic [2:0]  an_b;
  logic [6:0]  seg_b;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)
  ) dut_a (
    .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(rdy_a),
    .upd_digits(upd_digits), .upd_dp(upd_dp), .upd_blank(upd_blank),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_done(fd_a)
  );

  seg_scan_ctrl #(
    .NUM_DIGITS(3), .REFRESH_DIV(5), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(0), .LZ_SUPPRESS(1)
  ) dut_b (
    .clk(clk), .reset(reset), .upd_valid(1'b0), .upd_ready(rdy_b),
    .upd_digits(12'h000), .upd_dp(3'b000), .upd_blank(3'b000),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(fd_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Display for cycle k of the scan: returns {an[3:0], seg[6:0], dp}.
  function automatic logic [11:0] exp_out(input int k, input int n, input int div,
                                          input int blank, input bit al,
                                          input logic [15:0] dig, input logic [3:0] dpv,
                                          input logic [3:0] blk);
    int cnt = k % div;
    int idx = (k / div) % n;
    logic [3:0] anv;
    logic [6:0] s;
    logic d;
    bit lz;
    if (cnt < blank) return {(al ? 4'hF : 4'h0), 7'h7F, 1'b1};
    anv = 4'b0001 << idx;
    if (al) anv = ~anv;
    lz = (idx >= 1);
    for (int j = idx; j < n; j++) begin
      if (dig[4*j +: 4] != 4'h0) lz = 0;
    end
    if (blk[idx]) begin
      s = 7'h7F;
      d = 1'b1;
    end else begin
      s = lz ? 7'h7F : hex_tab[dig[4*idx +: 4]];
      d = ~dpv[idx];
    end
    return {anv, s, d};
  endfunction

  int          m_k    = 0;
  bit          m_pend = 0;
  logic [15:0] m_shd_dig = '0, m_act_dig = '0;
  logic [3:0]  m_shd_dp  = '0, m_act_dp  = '0;
  logic [3:0]  m_shd_blk = '0, m_act_blk = '0;
  logic [11:0] ea = {4'hF, 7'h7F, 1'b1};
  logic [11:0] eb = {4'h0, 7'h7F, 1'b1};
  bit          ea_fd = 0, eb_fd = 0, e_rdy = 1;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_k = 0; m_pend = 0;
        m_shd_dig = '0; m_shd_dp = '0; m_shd_blk = '0;
        m_act_dig = '0; m_act_dp = '0; m_act_blk = '0;
        ea = {4'hF, 7'h7F, 1'b1};
        eb = {4'h0, 7'h7F, 1'b1};
        ea_fd = 0; eb_fd = 0; e_rdy = 1;
      end else begin
        ea    = exp_out(m_k, 4, 8, 2, 1'b1, m_act_dig, m_act_dp, m_act_blk);
        eb    = exp_out(m_k, 3, 5, 2, 1'b0, 16'h0, 4'h0, 4'h0);
        ea_fd = (m_k % 32) == 31;
        eb_fd = (m_k % 15) == 14;
        if (((m_k % 32) == 31) && m_pend) begin
          m_act_dig = m_shd_dig; m_act_dp = m_shd_dp; m_act_blk = m_shd_blk;
          m_pend = 0;
        end else if (upd_valid && !m_pend) begin
          m_shd_dig = upd_digits; m_shd_dp = upd_dp; m_shd_blk = upd_blank;
          m_pend = 1;
        end
        m_k++;
        e_rdy = !m_pend;
      end
    end
  end

  // Scoreboard: compare both instances every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("a_an",    32'(an_a),  32'(ea[11:8]));
      check("a_seg",   32'(seg_a), 32'(ea[7:1]));
      check("a_dp",    32'(dp_a),  32'(ea[0]));
      check("a_frame", 32'(fd_a),  32'(ea_fd));
      check("a_ready", 32'(rdy_a), 32'(e_rdy));
      check("b_an",    32'(an_b),  32'(eb[10:8]));
      check("b_seg",   32'(seg_b), 32'(eb[7:1]));
      check("b_dp",    32'(dp_b),  32'(eb[0]));
      check("b_frame", 32'(fd_b),  32'(eb_fd));
      check("b_ready", 32'(rdy_b), 32'(1'b1));
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge. Holds valid until ready is seen (transfer on the
  // next rising edge) or max_hold cycles pass, in which case valid is dropped.
  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                       input int max_hold, output bit taken);
    int n = 0;
    upd_digits = d; upd_dp = p; upd_blank = b; upd_valid = 1'b1;
    while (!rdy_a && n < max_hold) begin
      @(negedge clk);
      n++;
    end
    taken = rdy_a;
    if (taken) @(negedge clk);
    upd_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an_a"},  32'(an_a),  32'(4'hF));
    check({tag, "_seg_a"}, 32'(seg_a), 32'(7'h7F));
    check({tag, "_dp_a"},  32'(dp_a),  32'(1'b1));
    check({tag, "_fd_a"},  32'(fd_a),  32'(1'b0));
    check({tag, "_rdy_a"}, 32'(rdy_a), 32'(1'b1));
    check({tag, "_an_b"},  32'(an_b),  32'(3'b000));
  endtask

  initial begin
    bit ok;
    logic [15:0] d;
    int z;
    reset = 1'b1; upd_valid = 1'b0;
    upd_digits = '0; upd_dp = '0; upd_blank = '0;
    idle(3);
    check_reset_outputs("por");
    reset = 1'b0;

    // Idle display of the all-zero image.
    idle(64);

    // First image, then a second one offered while the first is pending.
    offer(16'h0123, 4'b0010, 4'b0000, 100, ok);
    check("hs1_taken", 32'(ok), 32'(1'b1));
    offer(16'h4567, 4'b1000, 4'b0000, 100, ok);
    check("hs2_taken", 32'(ok), 32'(1'b1));
    idle(80);

    // Forced blanking of one digit.
    offer(16'h8888, 4'b0000, 4'b0100, 100, ok);
    check("hs3_taken", 32'(ok), 32'(1'b1));
    idle(80);

    // Random images, random leading zeros, random hold lengths (some dropped early).
    repeat (30) begin
      d = 16'($urandom);
      z = $urandom_range(0, 4);
      for (int j = 0; j < z; j++) d[4*(3-j) +: 4] = 4'h0;
      offer(d, 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            $urandom_range(1, 40), ok);
      idle($urandom_range(0, 20));
    end
    idle(40);

    // Mid-slot reset with an update pending.
    offer(16'h9ABC, 4'b1111, 4'b0000, 100, ok);
    check("hs4_taken", 32'(ok), 32'(1'b1));
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("mid");
    idle(2);
    reset = 1'b0;
    idle(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
